// File: rtl/csr_file_pkg.sv
// Shared CSR op codes, CSR addresses, mstatus bit positions and helpers for csr_file.
// The counter addresses are only populated when CSR_COUNTERS_EN is defined.
`define CSR_OP_NONE   8'h00
`define CSR_OP_ECALL  8'h01
`define CSR_OP_MRET   8'h02
`define CSR_OP_CSRRW  8'h04
`define CSR_OP_CSRRS  8'h08

`define CSR_MSTATUS   12'h300
`define CSR_MTVEC     12'h305
`define CSR_MEPC      12'h341
`define CSR_MCAUSE    12'h342
`define CSR_MVENDORID 12'hF11
`define CSR_MARCHID   12'hF12
`define CSR_MCYCLE    12'hB00
`define CSR_MCYCLEH   12'hB80
`define CSR_MINSTRET  12'hB02
`define CSR_MINSTRETH 12'hB82

`define MSTATUS_MIE   3
`define MSTATUS_MPIE  7

package csr_file_pkg;

  localparam logic [31:0] MSTATUS_BASE   = 32'h0000_1800;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] ALIGN4_MASK    = 32'hFFFF_FFFC;

  // MPP is hard-wired to machine mode; only MIE/MPIE are live bits.
  function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
    logic [31:0] v;
    v = MSTATUS_BASE;
    v[`MSTATUS_MIE]  = mie;
    v[`MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and per-half write; a write suppresses the increment.
import csr_file_pkg::*;

module csr_counter64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  // Written half takes the data, the other half holds, so no carry crosses on a write cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= 64'd0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with ECALL/MRET redirect; define CSR_COUNTERS_EN for mcycle/minstret.
import csr_file_pkg::*;

module csr_file #(
  parameter logic [31:0] VENDOR_ID = 32'h7973_7978,
  parameter logic [31:0] ARCH_ID   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        commit_valid_i,
  input  logic        commit_csr_i,
  input  logic [7:0]  csr_op_i,
  input  logic        csr_wena_i,
  input  logic [31:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  logic        acc;
  logic        is_ecall;
  logic        is_mret;
  logic        gen_wr;
  logic [11:0] waddr;
  logic        unused_waddr_hi;

  logic        mie;
  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;

  assign acc             = commit_valid_i & commit_csr_i;
  assign waddr           = csr_waddr_i[11:0];
  assign unused_waddr_hi = ^csr_waddr_i[31:12];
  assign is_ecall        = acc && (csr_op_i == `CSR_OP_ECALL);
  assign is_mret         = acc && (csr_op_i == `CSR_OP_MRET);
  // A trap op claims the cycle; its generic write (if any) is discarded.
  assign gen_wr          = acc & csr_wena_i & ~is_ecall & ~is_mret;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  csr_counter64 u_mcycle (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (gen_wr && (waddr == `CSR_MCYCLE)),
    .wr_hi (gen_wr && (waddr == `CSR_MCYCLEH)),
    .wdata (csr_wdata_i),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clock (clock),
    .reset (reset),
    .inc   (commit_valid_i),
    .wr_lo (gen_wr && (waddr == `CSR_MINSTRET)),
    .wr_hi (gen_wr && (waddr == `CSR_MINSTRETH)),
    .wdata (csr_wdata_i),
    .value (minstret)
  );
`endif

  // Architectural state update and registered redirect generation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mie              <= 1'b0;
      mpie             <= 1'b0;
      mtvec            <= 32'd0;
      mepc             <= 32'd0;
      mcause           <= 32'd0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'd0;
    end else begin
      // Back-to-back traps collapse into a single flush pulse.
      redirect_valid_o <= (is_ecall | is_mret) & ~redirect_valid_o;
      if (is_ecall) begin
        mepc          <= csr_wdata_i & ALIGN4_MASK;
        mcause        <= MCAUSE_ECALL_M;
        mpie          <= mie;
        mie           <= 1'b0;
        redirect_pc_o <= mtvec;
      end else if (is_mret) begin
        mie           <= mpie;
        mpie          <= 1'b1;
        redirect_pc_o <= mepc;
      end else if (gen_wr) begin
        case (waddr)
          `CSR_MSTATUS: begin
            mie  <= csr_wdata_i[`MSTATUS_MIE];
            mpie <= csr_wdata_i[`MSTATUS_MPIE];
          end
          `CSR_MTVEC:  mtvec  <= csr_wdata_i & ALIGN4_MASK;
          `CSR_MEPC:   mepc   <= csr_wdata_i & ALIGN4_MASK;
          `CSR_MCAUSE: mcause <= csr_wdata_i;
          default: begin
            mtvec <= mtvec;
          end
        endcase
      end else begin
        redirect_pc_o <= redirect_pc_o;
      end
    end
  end

  // Combinational read port from current state; no same-cycle write bypass.
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      `CSR_MSTATUS:   rdata_o = mstatus_view(mie, mpie);
      `CSR_MTVEC:     rdata_o = mtvec;
      `CSR_MEPC:      rdata_o = mepc;
      `CSR_MCAUSE:    rdata_o = mcause;
      `CSR_MVENDORID: rdata_o = VENDOR_ID;
      `CSR_MARCHID:   rdata_o = ARCH_ID;
`ifdef CSR_COUNTERS_EN
      `CSR_MCYCLE:    rdata_o = mcycle[31:0];
      `CSR_MCYCLEH:   rdata_o = mcycle[63:32];
      `CSR_MINSTRET:  rdata_o = minstret[31:0];
      `CSR_MINSTRETH: rdata_o = minstret[63:32];
`endif
      default:        rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed, table-driven bench for csr_file; counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;

  localparam logic [7:0] OP_NONE  = 8'h00;
  localparam logic [7:0] OP_ECALL = 8'h01;
  localparam logic [7:0] OP_MRET  = 8'h02;
  localparam logic [7:0] OP_CSRRW = 8'h04;

  logic        clock;
  logic        reset;
  logic        commit_valid_i;
  logic        commit_csr_i;
  logic [7:0]  csr_op_i;
  logic        csr_wena_i;
  logic [31:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [11:0] raddr_i;
  logic [31:0] rdata_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int checks   = 0;
  int failures = 0;

  csr_file dut (
    .clock            (clock),
    .reset            (reset),
    .commit_valid_i   (commit_valid_i),
    .commit_csr_i     (commit_csr_i),
    .csr_op_i         (csr_op_i),
    .csr_wena_i       (csr_wena_i),
    .csr_waddr_i      (csr_waddr_i),
    .csr_wdata_i      (csr_wdata_i),
    .raddr_i          (raddr_i),
    .rdata_o          (rdata_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        cv;
    logic        cc;
    logic [7:0]  op;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] exp_rd;
    logic        exp_rv;
    logic        chk_pc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic cc, input logic [7:0] op, input logic we,
                     input logic [31:0] wa, input logic [31:0] wd, input logic [11:0] ra,
                     input logic [31:0] exp_rd, input logic exp_rv, input logic chk_pc,
                     input logic [31:0] exp_pc);
    vec_t v;
    v.cv = cv; v.cc = cc; v.op = op; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
    v.exp_rd = exp_rd; v.exp_rv = exp_rv; v.chk_pc = chk_pc; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic cv, input logic cc, input logic [7:0] op, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [11:0] ra);
    commit_valid_i = cv;
    commit_csr_i   = cc;
    csr_op_i       = op;
    csr_wena_i     = we;
    csr_waddr_i    = wa;
    csr_wdata_i    = wd;
    raddr_i        = ra;
  endtask

  task automatic idle(input logic [11:0] ra);
    drive(1'b0, 1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, ra);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [11:0] ra, input logic [31:0] exp);
    raddr_i = ra;
    #1;
    check(name, rdata_o, exp);
  endtask

  initial begin
    reset = 1'b1;
    idle(12'h300);
    // Vectors: inputs applied after an edge, outputs compared before the next edge.
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h300,32'h0000_1800,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h305,32'h0000_0000,0,1,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h341,32'h0000_0000,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h342,32'h0000_0000,0,0,32'h0);
    add(1,1,OP_CSRRW,1,32'h305       ,32'h8000_0103 ,12'h305,32'h0000_0000,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h305,32'h8000_0100,0,0,32'h0);
    add(1,1,OP_CSRRW,1,32'h300       ,32'h0000_0008 ,12'h300,32'h0000_1800,0,0,32'h0);
    add(1,1,OP_ECALL,0,32'h0         ,32'h8000_0040 ,12'h300,32'h0000_1808,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h341,32'h8000_0040,1,1,32'h8000_0100);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h342,32'h0000_000B,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h300,32'h0000_1880,0,0,32'h0);
    add(1,1,OP_MRET ,0,32'h0         ,32'h0         ,12'h300,32'h0000_1880,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h300,32'h0000_1888,1,1,32'h8000_0040);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h341,32'h8000_0040,0,1,32'h8000_0040);
    add(1,0,OP_CSRRW,1,32'h341       ,32'h1234_5678 ,12'h341,32'h8000_0040,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h341,32'h8000_0040,0,0,32'h0);
    add(1,1,OP_CSRRW,1,32'hF11       ,32'h0000_0000 ,12'hF11,32'h7973_7978,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'hF11,32'h7973_7978,0,0,32'h0);
    add(1,1,OP_ECALL,1,32'h342       ,32'h0000_1003 ,12'h342,32'h0000_000B,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h342,32'h0000_000B,1,1,32'h8000_0100);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h341,32'h0000_1000,0,0,32'h0);
    add(1,1,OP_CSRRW,1,32'h341       ,32'hFFFF_FFFF ,12'h123,32'h0000_0000,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h341,32'hFFFF_FFFC,0,0,32'h0);
    add(1,1,OP_CSRRW,1,32'hABCD_5342 ,32'hDEAD_BEEF ,12'hF12,32'h0000_0000,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h342,32'hDEAD_BEEF,0,0,32'h0);
    add(1,1,OP_NONE ,1,32'h300       ,32'hFFFF_FFFF ,12'h300,32'h0000_1880,0,0,32'h0);
    add(0,0,OP_NONE ,0,32'h0         ,32'h0         ,12'h300,32'h0000_1888,0,0,32'h0);

    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cv, vecs[i].cc, vecs[i].op, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra);
      #1;
      check($sformatf("v%0d_rdata", i), rdata_o, vecs[i].exp_rd);
      check($sformatf("v%0d_rvalid", i), {31'd0, redirect_valid_o}, {31'd0, vecs[i].exp_rv});
      if (vecs[i].chk_pc) check($sformatf("v%0d_rpc", i), redirect_pc_o, vecs[i].exp_pc);
      tick();
    end

    // Asynchronous reset in the middle of a redirect pulse.
    drive(1'b1, 1'b1, OP_ECALL, 1'b0, 32'd0, 32'h0000_0200, 12'h300);
    tick();
    idle(12'h300);
    #1;
    check("pre_reset_rvalid", {31'd0, redirect_valid_o}, 32'd1);
    check("pre_reset_rpc", redirect_pc_o, 32'h8000_0100);
    reset = 1'b1;
    #1;
    check("async_reset_rvalid", {31'd0, redirect_valid_o}, 32'd0);
    check("async_reset_rpc", redirect_pc_o, 32'd0);
    read_chk("async_reset_mstatus", 12'h300, 32'h0000_1800);
    read_chk("async_reset_mepc", 12'h341, 32'd0);
    read_chk("async_reset_mtvec", 12'h305, 32'd0);
    tick();
    reset = 1'b0;

`ifdef CSR_COUNTERS_EN
    // mcycle low-half preset, then carry into the high half.
    drive(1'b1, 1'b1, OP_CSRRW, 1'b1, 32'hB00, 32'hFFFF_FFFF, 12'hB00);
    tick();
    idle(12'hB00);
    tick();
    tick();
    read_chk("mcycleh_carry", 12'hB80, 32'd1);
    read_chk("mcycle_wrap", 12'hB00, 32'd1);
    // minstret write wins over the same-cycle increment, then counts plain commits.
    drive(1'b1, 1'b1, OP_CSRRW, 1'b1, 32'hB02, 32'd0, 12'hB02);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 12'hB02);
      tick();
    end
    idle(12'hB02);
    tick();
    read_chk("minstret_count", 12'hB02, 32'd5);
    read_chk("minstreth_zero", 12'hB82, 32'd0);
`else
    drive(1'b1, 1'b1, OP_CSRRW, 1'b1, 32'hB00, 32'h0000_0005, 12'hB00);
    tick();
    idle(12'hB00);
    tick();
    read_chk("mcycle_absent", 12'hB00, 32'd0);
    read_chk("minstret_absent", 12'hB02, 32'd0);
    read_chk("mcycleh_absent", 12'hB80, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
